// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write path.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_e;

    // Round-robin successor of a granted index, wrapping at n.
    function automatic int next_ptr(input int g, input int n);
        return ((g + 1) >= n) ? 0 : (g + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic found_s;
    int   idx_s;

    // Scan the requests starting from the pointer; the first hit wins.
    always_comb begin
        gnt     = {N{1'b0}};
        found_s = 1'b0;
        idx_s   = 0;
        for (int i = 0; i < N; i++) begin
            idx_s = (int'(ptr) + i) % N;
            for (int k = 0; k < N; k++) begin
                if (!found_s && (k == idx_s) && req[k]) begin
                    gnt[k]  = 1'b1;
                    found_s = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port controller: round-robin writeback arbitration plus an
// optional x1..x31 zeroing sweep, enabled with the REGFILE_CLEAR_EN macro.
module regfile_wr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic                      i_clear,
    output logic                      o_wr_en,
    output logic [ADDR_W-1:0]         o_wr_addr,
    output logic [DATA_W-1:0]         o_wr_data,
    output logic                      o_busy
);

    import regfile_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef REGFILE_CLEAR_EN
    localparam state_e RESET_STATE = CLEAR;
    localparam logic [ADDR_W-1:0] FIRST_ADDR = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
`else
    localparam state_e RESET_STATE = ARB;
`endif

    state_e              state_r;
    logic [PTR_W-1:0]    ptr_r;
    logic                wr_en_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [DATA_W-1:0]   wr_data_r;
`ifdef REGFILE_CLEAR_EN
    logic [ADDR_W-1:0]   cnt_r;
`endif

    logic                clear_s;
    logic                arb_en_s;
    logic [NUM_REQ-1:0]  arb_req_s;
    logic [NUM_REQ-1:0]  gnt_s;
    logic                gnt_any_s;
    logic [PTR_W-1:0]    gnt_idx_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_data_s;

`ifdef REGFILE_CLEAR_EN
    assign clear_s = i_clear;
    assign o_busy  = (state_r == CLEAR);
`else
    // Without the sweep the clear input has no effect and busy never rises.
    assign clear_s = 1'b0;
    assign o_busy  = 1'b0 & i_clear;
`endif

    // A clear request in ARB takes the cycle, so no grant may be issued alongside it.
    assign arb_en_s  = (state_r == ARB) && !clear_s;
    assign arb_req_s = i_req_valid & {NUM_REQ{arb_en_s}};

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req (arb_req_s),
        .ptr (ptr_r),
        .gnt (gnt_s)
    );

    assign o_req_ready = gnt_s;
    assign gnt_any_s   = |gnt_s;

    // One-hot AND-OR select of the granted requester's address, data and index.
    always_comb begin
        sel_addr_s = {ADDR_W{1'b0}};
        sel_data_s = {DATA_W{1'b0}};
        gnt_idx_s  = {PTR_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_addr_s = sel_addr_s | (gnt_s[k] ? i_req_addr[k*ADDR_W +: ADDR_W] : {ADDR_W{1'b0}});
            sel_data_s = sel_data_s | (gnt_s[k] ? i_req_data[k*DATA_W +: DATA_W] : {DATA_W{1'b0}});
            gnt_idx_s  = gnt_idx_s  | (gnt_s[k] ? PTR_W'(k) : {PTR_W{1'b0}});
        end
    end

    // Controller FSM with the write-port output register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= RESET_STATE;
            ptr_r     <= {PTR_W{1'b0}};
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= {DATA_W{1'b0}};
`ifdef REGFILE_CLEAR_EN
            cnt_r     <= FIRST_ADDR;
`endif
        end else begin
            case (state_r)
                ARB: begin
                    if (clear_s) begin
                        state_r <= CLEAR;
                        wr_en_r <= 1'b0;
                    end else if (gnt_any_s) begin
                        // x0 is hardwired, so its write is consumed but not enabled.
                        wr_en_r   <= (sel_addr_s != {ADDR_W{1'b0}});
                        wr_addr_r <= sel_addr_s;
                        wr_data_r <= sel_data_s;
                        ptr_r     <= PTR_W'(next_ptr(int'(gnt_idx_s), NUM_REQ));
                    end else begin
                        wr_en_r <= 1'b0;
                    end
                end
`ifdef REGFILE_CLEAR_EN
                CLEAR: begin
                    wr_en_r   <= 1'b1;
                    wr_addr_r <= cnt_r;
                    wr_data_r <= {DATA_W{1'b0}};
                    if (cnt_r == LAST_ADDR) begin
                        state_r <= ARB;
                        cnt_r   <= FIRST_ADDR;
                    end else begin
                        cnt_r   <= cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
`endif
                default: begin
                    state_r <= RESET_STATE;
                    wr_en_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_wr_en   = wr_en_r;
    assign o_wr_addr = wr_addr_r;
    assign o_wr_data = wr_data_r;

endmodule
